// File: rtl/decode_pipeline.sv
// ---------------------------------------------------------------------------
// decode_pipeline
//   Decode stage of the 5-stage RV32I core. Decodes the instruction held in
//   IF/ID, reads the 32x32 register file (written back from the WB stage)
//   and registers the result into the ID/EX bundle consumed by execute.
//
// Ports
//   clk, rst                 rising-edge clock, asynchronous active-low reset
//   Instr_D, PC_D, PCPlusD   IF/ID contents (word-addressed PC, PC+1)
//   stall_d                  hold ID/EX contents this cycle
//   flush_e                  load a bubble (controls cleared) into ID/EX
//   RegWriteW, RDW, ResultW  register-file write port from write-back
//   RD1_E, RD2_E             rs1/rs2 operand values
//   Imm_Ext_E                sign-extended immediate
//   PC_E, PCPlus_E           PC_D / PCPlusD passed through
//   RS1_E, RS2_E, RD_E       register indices
//   RegWrite_E .. Jump_E     single-bit controls
//   ResultSrc_E              00 ALU, 01 memory, 10 PC+1
//   ALUControl_E             000 add, 001 sub, 010 and, 011 or, 101 slt
//   Illegal_E                instruction outside the supported subset
// ---------------------------------------------------------------------------
module decode_pipeline #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] Instr_D,
   input  logic [XLEN-1:0] PC_D,
   input  logic [XLEN-1:0] PCPlusD,
   input  logic            stall_d,
   input  logic            flush_e,
   input  logic            RegWriteW,
   input  logic [4:0]      RDW,
   input  logic [XLEN-1:0] ResultW,
   output logic [XLEN-1:0] RD1_E,
   output logic [XLEN-1:0] RD2_E,
   output logic [XLEN-1:0] Imm_Ext_E,
   output logic [XLEN-1:0] PC_E,
   output logic [XLEN-1:0] PCPlus_E,
   output logic [4:0]      RS1_E,
   output logic [4:0]      RS2_E,
   output logic [4:0]      RD_E,
   output logic            RegWrite_E,
   output logic            MemWrite_E,
   output logic            ALUSrc_E,
   output logic            Branch_E,
   output logic            Jump_E,
   output logic [1:0]      ResultSrc_E,
   output logic [2:0]      ALUControl_E,
   output logic            Illegal_E
);

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic            funct7_b5;
   logic [4:0]      rs1;
   logic [4:0]      rs2;
   logic [4:0]      rd;

   logic [XLEN-1:0] regs [NREGS];
   logic [XLEN-1:0] rd1;
   logic [XLEN-1:0] rd2;

   logic            dec_regw;
   logic            dec_memw;
   logic            dec_alusrc;
   logic            dec_br;
   logic            dec_jmp;
   logic [1:0]      dec_ressrc;
   logic [2:0]      dec_alu;
   logic            dec_ill;
   logic [XLEN-1:0] dec_imm;
   logic [3:0]      alu_fn;

   assign opcode    = Instr_D[6:0];
   assign funct3    = Instr_D[14:12];
   assign funct7_b5 = Instr_D[30];
   assign rs1       = Instr_D[19:15];
   assign rs2       = Instr_D[24:20];
   assign rd        = Instr_D[11:7];

   // ALU decode shared by R- and I-type; returns {illegal, alu control}.
   // sub_sel is only ever true for R-type, so addi never turns into sub.
   function automatic logic [3:0] alu_decode(input logic [2:0] f3,
                                             input logic       sub_sel);
      logic [3:0] res;
      case (f3)
         3'b000:  res = {1'b0, (sub_sel ? ALU_SUB : ALU_ADD)};
         3'b010:  res = {1'b0, ALU_SLT};
         3'b110:  res = {1'b0, ALU_OR};
         3'b111:  res = {1'b0, ALU_AND};
         default: res = {1'b1, ALU_ADD};
      endcase
      return res;
   endfunction

   // Register file write port. x0 is never written, so it stays zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (RegWriteW && (RDW != 5'd0)) begin
         regs[RDW] <= ResultW;
      end
   end

   // Write-through read: a same-edge write-back wins over the stored value.
   always_comb begin
      rd1 = '0;
      rd2 = '0;
      if (rs1 != 5'd0) begin
         rd1 = (RegWriteW && (RDW == rs1)) ? ResultW : regs[rs1];
      end
      if (rs2 != 5'd0) begin
         rd2 = (RegWriteW && (RDW == rs2)) ? ResultW : regs[rs2];
      end
   end

   // Main decoder. Anything illegal (bad opcode or bad funct3) is turned
   // into a bubble so it cannot write state further down the pipe.
   always_comb begin
      dec_regw   = 1'b0;
      dec_memw   = 1'b0;
      dec_alusrc = 1'b0;
      dec_br     = 1'b0;
      dec_jmp    = 1'b0;
      dec_ressrc = 2'b00;
      dec_alu    = ALU_ADD;
      dec_ill    = 1'b0;
      dec_imm    = '0;
      alu_fn     = '0;
      case (opcode)
         OP_R: begin
            alu_fn   = alu_decode(funct3, funct7_b5);
            dec_regw = 1'b1;
            dec_alu  = alu_fn[2:0];
            dec_ill  = alu_fn[3];
         end
         OP_I: begin
            alu_fn     = alu_decode(funct3, 1'b0);
            dec_regw   = 1'b1;
            dec_alusrc = 1'b1;
            dec_alu    = alu_fn[2:0];
            dec_ill    = alu_fn[3];
            dec_imm    = {{20{Instr_D[31]}}, Instr_D[31:20]};
         end
         OP_LW: begin
            dec_regw   = 1'b1;
            dec_alusrc = 1'b1;
            dec_ressrc = 2'b01;
            dec_imm    = {{20{Instr_D[31]}}, Instr_D[31:20]};
         end
         OP_SW: begin
            dec_memw   = 1'b1;
            dec_alusrc = 1'b1;
            dec_imm    = {{20{Instr_D[31]}}, Instr_D[31:25], Instr_D[11:7]};
         end
         OP_BEQ: begin
            dec_br  = 1'b1;
            dec_alu = ALU_SUB;
            dec_imm = {{19{Instr_D[31]}}, Instr_D[31], Instr_D[7],
                       Instr_D[30:25], Instr_D[11:8], 1'b0};
         end
         OP_JAL: begin
            dec_regw   = 1'b1;
            dec_jmp    = 1'b1;
            dec_ressrc = 2'b10;
            dec_imm    = {{11{Instr_D[31]}}, Instr_D[31], Instr_D[19:12],
                          Instr_D[20], Instr_D[30:21], 1'b0};
         end
         default: begin
            dec_ill = 1'b1;
         end
      endcase
      if (dec_ill) begin
         dec_regw   = 1'b0;
         dec_memw   = 1'b0;
         dec_alusrc = 1'b0;
         dec_br     = 1'b0;
         dec_jmp    = 1'b0;
         dec_ressrc = 2'b00;
         dec_alu    = ALU_ADD;
      end
   end

   // ID/EX register. Flush beats stall; a flush only has to neutralise the
   // controls, so the data fields load normally to keep their logic simple.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         RD1_E        <= '0;
         RD2_E        <= '0;
         Imm_Ext_E    <= '0;
         PC_E         <= '0;
         PCPlus_E     <= '0;
         RS1_E        <= '0;
         RS2_E        <= '0;
         RD_E         <= '0;
         RegWrite_E   <= 1'b0;
         MemWrite_E   <= 1'b0;
         ALUSrc_E     <= 1'b0;
         Branch_E     <= 1'b0;
         Jump_E       <= 1'b0;
         ResultSrc_E  <= 2'b00;
         ALUControl_E <= 3'b000;
         Illegal_E    <= 1'b0;
      end else begin
         if (flush_e || !stall_d) begin
            RD1_E     <= rd1;
            RD2_E     <= rd2;
            Imm_Ext_E <= dec_imm;
            PC_E      <= PC_D;
            PCPlus_E  <= PCPlusD;
            RS1_E     <= rs1;
            RS2_E     <= rs2;
            RD_E      <= rd;
         end
         if (flush_e) begin
            RegWrite_E   <= 1'b0;
            MemWrite_E   <= 1'b0;
            ALUSrc_E     <= 1'b0;
            Branch_E     <= 1'b0;
            Jump_E       <= 1'b0;
            ResultSrc_E  <= 2'b00;
            ALUControl_E <= 3'b000;
            Illegal_E    <= 1'b0;
         end else if (!stall_d) begin
            RegWrite_E   <= dec_regw;
            MemWrite_E   <= dec_memw;
            ALUSrc_E     <= dec_alusrc;
            Branch_E     <= dec_br;
            Jump_E       <= dec_jmp;
            ResultSrc_E  <= dec_ressrc;
            ALUControl_E <= dec_alu;
            Illegal_E    <= dec_ill;
         end
      end
   end

endmodule
